// File: rtl/csd_lut_stream_monitor_pkg.sv
// Shared definitions for the CSD stream monitor: digit codes, channel-index width,
// and the fixed-point scaling helper used only when CSD_MON_REAL_OUT_EN is defined.
package csd_lut_stream_monitor_pkg;

    localparam logic [1:0] ZERO = 2'b00;
    localparam logic [1:0] POS  = 2'b01;
    localparam logic [1:0] NEG  = 2'b11;
    localparam logic [1:0] INV  = 2'b10;

    // Width of a channel tag: never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

`ifdef CSD_MON_REAL_OUT_EN
    function automatic real fx_scale(input real v, input int frac_bits);
        return v / (2.0 ** frac_bits);
    endfunction
`endif

endpackage

// File: rtl/csd_lut_stream_monitor_csd2bin.sv
// Combinational CSD-to-two's-complement converter; invalid digit codes contribute 0.
module csd2bin
    import csd_lut_stream_monitor_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [2*W-1:0] csd,
    output logic [W-1:0]   bin_c
);

    logic [W-1:0] pos;
    logic [W-1:0] neg;

    // Value is (sum of +1 weights) - (sum of -1 weights), modulo 2^W.
    always_comb begin
        pos = '0;
        neg = '0;
        for (int i = 0; i < int'(W); i++) begin
            pos[i] = (csd[2*i +: 2] == POS);
            neg[i] = (csd[2*i +: 2] == NEG);
        end
        bin_c = pos - neg;
    end

endmodule

// File: rtl/csd_lut_stream_monitor.sv
// Two-stage multi-channel CSD stream monitor: decode, canonicity check, error status.
// Optional real-typed outputs res_data/res_ctrl are enabled by CSD_MON_REAL_OUT_EN.
module csd_lut_stream_monitor
    import csd_lut_stream_monitor_pkg::*;
#(
    parameter int unsigned WD   = 73,
    parameter int unsigned WC   = 21,
    parameter int unsigned WI   = 11,
    parameter int unsigned NCH  = 4,
    parameter int unsigned WCNT = 16
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     srst,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [ch_width(NCH)-1:0] in_ch,
    input  logic [2*WD-1:0]          in_csd,
    input  logic [WC-1:0]            in_ctrl,
    input  logic                     clr_err,
    output logic                     out_valid,
    output logic [ch_width(NCH)-1:0] out_ch,
    output logic [WD-1:0]            out_bin,
    output logic [WC-1:0]            out_ctrl,
    output logic                     out_err,
    output logic [NCH-1:0]           err_mask,
    output logic [WCNT-1:0]          sample_cnt,
    output logic [WCNT-1:0]          err_cnt
`ifdef CSD_MON_REAL_OUT_EN
    ,
    output real                      res_data,
    output real                      res_ctrl
`endif
);

    localparam int unsigned CHW = ch_width(NCH);

    logic            s1_valid;
    logic [CHW-1:0]  s1_ch;
    logic [2*WD-1:0] s1_csd;
    logic [WC-1:0]   s1_ctrl;
    logic            s1_err;

    logic [WD-1:0]   nz_c;
    logic            inv_c;
    logic            adj_c;
    logic [WD-1:0]   dec_c;
    logic [NCH-1:0]  mask_set_c;

    // Input checks: any invalid code, or two adjacent nonzero digits.
    always_comb begin
        nz_c  = '0;
        inv_c = 1'b0;
        adj_c = 1'b0;
        for (int i = 0; i < int'(WD); i++) begin
            nz_c[i] = (in_csd[2*i +: 2] == POS) || (in_csd[2*i +: 2] == NEG);
            if (in_csd[2*i +: 2] == INV) begin
                inv_c = 1'b1;
            end
        end
        for (int i = 1; i < int'(WD); i++) begin
            if (nz_c[i] && nz_c[i-1]) begin
                adj_c = 1'b1;
            end
        end
    end

    // Stage 1: capture the word and its error flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_csd   <= '0;
            s1_ctrl  <= '0;
            s1_err   <= 1'b0;
        end else if (srst) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_csd   <= '0;
            s1_ctrl  <= '0;
            s1_err   <= 1'b0;
        end else if (enable) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ch   <= in_ch;
                s1_csd  <= in_csd;
                s1_ctrl <= in_ctrl;
                s1_err  <= inv_c | adj_c;
            end
        end
    end

    csd2bin #(
        .W (WD)
    ) u_csd2bin (
        .csd   (s1_csd),
        .bin_c (dec_c)
    );

    // Out-of-range channel tags select no mask bit.
    always_comb begin
        mask_set_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (s1_ch == CHW'(i)) begin
                mask_set_c[i] = 1'b1;
            end
        end
    end

    // Stage 2: outputs, counters and sticky mask; clr_err wins over a same-cycle set.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_bin    <= '0;
            out_ctrl   <= '0;
            out_err    <= 1'b0;
            err_mask   <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
        end else if (srst) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_bin    <= '0;
            out_ctrl   <= '0;
            out_err    <= 1'b0;
            err_mask   <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
        end else if (enable) begin
            out_valid <= s1_valid;
            out_err   <= s1_valid & s1_err;
            if (s1_valid) begin
                out_ch     <= s1_ch;
                out_bin    <= dec_c;
                out_ctrl   <= s1_ctrl;
                sample_cnt <= sample_cnt + WCNT'(1);
            end
            if (clr_err) begin
                err_mask <= '0;
                err_cnt  <= '0;
            end else if (s1_valid && s1_err) begin
                err_mask <= err_mask | mask_set_c;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + WCNT'(1);
                end
            end
        end
    end

`ifdef CSD_MON_REAL_OUT_EN
    always_comb begin
        res_data = fx_scale(real'($signed(out_bin)), int'(WD) - int'(WI));
        res_ctrl = fx_scale(real'($signed(out_ctrl)), int'(WC) - int'(WI));
    end
`endif

endmodule

// File: tb/tb_csd_lut_stream_monitor.sv
// Bench for csd_lut_stream_monitor (WD=8, WC=8, NCH=4, WCNT=4): vector table,
// hand sequences for stall/reset/saturation, and random traffic against a reference model.
module tb_csd_lut_stream_monitor;

    logic        clk;
    logic        arst_n;
    logic        srst;
    logic        enable;
    logic        in_valid;
    logic [1:0]  in_ch;
    logic [15:0] in_csd;
    logic [7:0]  in_ctrl;
    logic        clr_err;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [7:0]  out_bin;
    logic [7:0]  out_ctrl;
    logic        out_err;
    logic [3:0]  err_mask;
    logic [3:0]  sample_cnt;
    logic [3:0]  err_cnt;

    csd_lut_stream_monitor #(
        .WD   (8),
        .WC   (8),
        .WI   (4),
        .NCH  (4),
        .WCNT (4)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .srst       (srst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ch      (in_ch),
        .in_csd     (in_csd),
        .in_ctrl    (in_ctrl),
        .clr_err    (clr_err),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_bin    (out_bin),
        .out_ctrl   (out_ctrl),
        .out_err    (out_err),
        .err_mask   (err_mask),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the word waiting in the pipe, and the visible output state.
    logic        mp_v;
    logic [15:0] mp_csd;
    logic [1:0]  mp_ch;
    logic [7:0]  mp_ctrl;
    logic        m_ov;
    logic [1:0]  m_och;
    logic [7:0]  m_obin;
    logic [7:0]  m_octrl;
    logic        m_oerr;
    logic [3:0]  m_mask;
    int          m_scnt;
    int          m_ecnt;

    function automatic logic [7:0] ref_decode(input logic [15:0] c);
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            int code = int'((c >> (2*i)) & 16'h3);
            if (code == 1) s += (1 << i);
            else if (code == 3) s -= (1 << i);
        end
        return 8'(s);
    endfunction

    function automatic logic ref_err(input logic [15:0] c);
        int d[8];
        logic e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d[i] = int'((c >> (2*i)) & 16'h3);
            if (d[i] == 2) begin
                e = 1'b1;
                d[i] = 0;
            end
        end
        for (int i = 1; i < 8; i++)
            if (d[i] != 0 && d[i-1] != 0) e = 1'b1;
        return e;
    endfunction

    task automatic m_reset();
        mp_v = 0; mp_csd = '0; mp_ch = '0; mp_ctrl = '0;
        m_ov = 0; m_och = '0; m_obin = '0; m_octrl = '0; m_oerr = 0;
        m_mask = '0; m_scnt = 0; m_ecnt = 0;
    endtask

    task automatic model_edge(input logic en, input logic v, input logic [1:0] ch,
                              input logic [15:0] csd, input logic [7:0] ctrl,
                              input logic clr, input logic sr);
        if (sr) begin
            m_reset();
        end else if (en) begin
            m_ov = mp_v;
            m_oerr = 1'b0;
            if (mp_v) begin
                m_obin  = ref_decode(mp_csd);
                m_och   = mp_ch;
                m_octrl = mp_ctrl;
                m_oerr  = ref_err(mp_csd);
                m_scnt  = (m_scnt + 1) % 16;
                if (m_oerr) begin
                    if (m_ecnt < 15) m_ecnt++;
                    m_mask[mp_ch] = 1'b1;
                end
            end
            if (clr) begin
                m_mask = '0;
                m_ecnt = 0;
            end
            mp_v = v;
            if (v) begin
                mp_csd = csd; mp_ch = ch; mp_ctrl = ctrl;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name);
        chk(name, {out_valid, out_ch, out_bin, out_ctrl, out_err, err_mask, sample_cnt, err_cnt},
                  {m_ov, m_och, m_obin, m_octrl, m_oerr, m_mask, 4'(m_scnt), 4'(m_ecnt)});
    endtask

    task automatic cyc(input string name, input logic en, input logic v, input logic [1:0] ch,
                       input logic [15:0] csd, input logic [7:0] ctrl,
                       input logic clr, input logic sr);
        enable = en; in_valid = v; in_ch = ch; in_csd = csd; in_ctrl = ctrl;
        clr_err = clr; srst = sr;
        @(posedge clk);
        model_edge(en, v, ch, csd, ctrl, clr, sr);
        #1;
        check_all(name);
    endtask

    typedef struct {
        logic [15:0] csd;
        logic [1:0]  ch;
        logic [7:0]  ctrl;
        logic [7:0]  bin;
        logic        err;
        logic [3:0]  mask;
        logic [3:0]  ecnt;
        logic [3:0]  scnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'h0043, 2'd1, 8'h5A, 8'h07, 1'b0, 4'b0000, 4'd0, 4'd1};
        vecs[1] = '{16'hC000, 2'd0, 8'hA5, 8'h80, 1'b0, 4'b0000, 4'd0, 4'd2};
        vecs[2] = '{16'h0005, 2'd2, 8'h11, 8'h03, 1'b1, 4'b0100, 4'd1, 4'd3};
        vecs[3] = '{16'h0002, 2'd3, 8'h22, 8'h00, 1'b1, 4'b1000, 4'd1, 4'd4};
        vecs[4] = '{16'h0101, 2'd1, 8'h33, 8'h11, 1'b0, 4'b1000, 4'd1, 4'd5};
        vecs[5] = '{16'h00C1, 2'd0, 8'h44, 8'hF9, 1'b0, 4'b1000, 4'd1, 4'd6};
        vecs[6] = '{16'hFFFF, 2'd2, 8'h55, 8'h01, 1'b1, 4'b1100, 4'd2, 4'd7};

        arst_n = 0; srst = 0; enable = 0; in_valid = 0; in_ch = '0;
        in_csd = '0; in_ctrl = '0; clr_err = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #5 arst_n = 1;
        #1;
        chk("reset_state", {out_valid, out_ch, out_bin, out_ctrl, out_err, err_mask, sample_cnt, err_cnt}, 32'h0);

        // Vector table: one word, one bubble, then compare against fixed expectations.
        for (int i = 0; i < 7; i++) begin
            cyc("vec_in", 1, 1, vecs[i].ch, vecs[i].csd, vecs[i].ctrl, 0, 0);
            cyc("vec_bub", 1, 0, 2'd0, 16'h0, 8'h0, 0, 0);
            chk("vec_out", {out_valid, out_ch, out_bin, out_ctrl, out_err},
                {1'b1, vecs[i].ch, vecs[i].bin, vecs[i].ctrl, vecs[i].err});
            chk("vec_stat", {err_mask, err_cnt, sample_cnt},
                {vecs[i].mask, vecs[i].ecnt, vecs[i].scnt});
            if (i == 2) begin
                cyc("clr", 1, 0, 2'd0, 16'h0, 8'h0, 1, 0);
                chk("clr_stat", {out_valid, out_err, err_mask, err_cnt, sample_cnt},
                    {1'b0, 1'b0, 4'b0000, 4'd0, 4'd3});
            end
        end

        // Stall: three back-to-back words, enable low for two cycles.
        cyc("stall_w1", 1, 1, 2'd1, 16'h0001, 8'h01, 0, 0);
        cyc("stall_w2", 1, 1, 2'd2, 16'h0010, 8'h02, 0, 0);
        cyc("stall_w3", 1, 1, 2'd3, 16'h0300, 8'h03, 0, 0);
        cyc("stall_h1", 0, 1, 2'd0, 16'hFFFF, 8'hFF, 0, 0);
        cyc("stall_h2", 0, 0, 2'd0, 16'h0000, 8'h00, 0, 0);
        chk("stall_hold", {out_valid, out_ch, out_bin, out_ctrl}, {1'b1, 2'd2, 8'h04, 8'h02});
        cyc("stall_r1", 1, 0, 2'd0, 16'h0, 8'h0, 0, 0);
        chk("stall_w3_out", {out_valid, out_bin}, {1'b1, 8'hF0});
        cyc("stall_r2", 1, 0, 2'd0, 16'h0, 8'h0, 0, 0);

        // Asynchronous reset with words in flight.
        cyc("ar_w1", 1, 1, 2'd1, 16'h0004, 8'h10, 0, 0);
        cyc("ar_w2", 1, 1, 2'd2, 16'h0040, 8'h20, 0, 0);
        arst_n = 0;
        #1;
        m_reset();
        check_all("arst_now");
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        #3 arst_n = 1;
        for (int i = 0; i < 3; i++) cyc("arst_drain", 1, 0, 2'd0, 16'h0, 8'h0, 0, 0);

        // Synchronous reset overrides a stalled pipeline.
        cyc("sr_w1", 1, 1, 2'd3, 16'h0002, 8'h30, 0, 0);
        cyc("sr_w2", 1, 1, 2'd0, 16'h0001, 8'h40, 0, 0);
        cyc("sr_hit", 0, 0, 2'd0, 16'h0, 8'h0, 0, 1);
        chk("srst_state", {out_valid, out_bin, sample_cnt, err_cnt, err_mask}, 32'd0);
        for (int i = 0; i < 3; i++) cyc("sr_drain", 1, 0, 2'd0, 16'h0, 8'h0, 0, 0);

        // Saturation: 17 erroneous words.
        for (int i = 0; i < 17; i++)
            cyc("sat_in", 1, 1, 2'(i), 16'h0002, 8'(i), 0, 0);
        cyc("sat_b1", 1, 0, 2'd0, 16'h0, 8'h0, 0, 0);
        chk("sat_cnt", {err_cnt, sample_cnt, err_mask}, {4'hF, 4'h1, 4'hF});
        cyc("sat_more", 1, 1, 2'd0, 16'h0002, 8'h0, 0, 0);
        cyc("sat_b2", 1, 0, 2'd0, 16'h0, 8'h0, 0, 0);
        chk("sat_hold", {err_cnt, sample_cnt}, {4'hF, 4'h2});

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] c;
            logic        prev_nz;
            c = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                prev_nz = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (prev_nz || c[2*i +: 2] == 2'b10) c[2*i +: 2] = 2'b00;
                    prev_nz = (c[2*i +: 2] != 2'b00);
                end
            end
            cyc("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), c,
                8'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
